// File: rtl/dsp_pkg.sv
// Shared definitions for the dot-product sequencer: FSM encoding and the
// saturating signed adder used by the accumulator.
package dsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int unsigned SAT_W  = 64;
  localparam int unsigned SAT_IW = 7;

  // Signed a+b clamped to the w-bit signed range (w <= SAT_W); clamped flags a clip.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input  logic signed [SAT_W-1:0] a,
    input  logic signed [SAT_W-1:0] b,
    input  int unsigned             w,
    output logic                    clamped
  );
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    hi = '0;
    hi[SAT_IW'(w - 1)] = 1'b1;
    hi = hi - $signed({{SAT_W{1'b0}}, 1'b1});
    lo = ~hi;
    clamped = 1'b0;
    if (sum > hi) begin
      sum     = hi;
      clamped = 1'b1;
    end else if (sum < lo) begin
      sum     = lo;
      clamped = 1'b1;
    end
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/dsp_dot_sequencer_tag_delay.sv
// Latency-matched 1-bit tag pipe; tag_o lines up with the dsp_group result,
// any_o reports whether any tagged beat is still in flight.
module tag_delay #(
  parameter int unsigned DEPTH = 7
) (
  input  logic clk,
  input  logic rstn,
  input  logic in_i,
  output logic tag_o,
  output logic any_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= DEPTH'({sr_q, in_i});
    end
  end

  assign tag_o = sr_q[DEPTH-1];
  assign any_o = |sr_q;

endmodule

// File: rtl/dsp_dot_sequencer.sv
// Job-level driver/collector for a dsp_group: streams operand beats into the
// group, accumulates the tagged results and hands back one dot product per job.
module dsp_dot_sequencer
  import dsp_pkg::*;
#(
  parameter int unsigned N_MUL   = 3,
  parameter int unsigned DSP_LAT = 7,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned ACC_W   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  busy,
  output logic                  done,
  input  logic [16*N_MUL-1:0]   s_wei,
  input  logic [16*N_MUL-1:0]   s_fm,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [16*N_MUL-1:0]   dsp_wei,
  output logic [16*N_MUL-1:0]   dsp_fm,
  input  logic [15:0]           dsp_res,
  output logic [ACC_W-1:0]      m_data,
  output logic                  m_sat,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int unsigned OPW = 16 * N_MUL;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         remain_q, remain_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic [OPW-1:0]           wei_q, wei_d;
  logic [OPW-1:0]           fm_q, fm_d;
  logic                     opv_q, opv_d;
  logic                     busy_q, busy_d;
  logic                     s_ready_q, s_ready_d;
  logic                     m_valid_q, m_valid_d;
  logic                     done_q, done_d;
  logic                     tag_c;
  logic                     any_c;
  logic                     clamp_c;
  logic                     accept_c;

  // opv_q marks a real beat on the operand bus; delaying it by DSP_LAT aligns it with dsp_res.
  tag_delay #(
    .DEPTH (DSP_LAT)
  ) u_tag_delay (
    .clk   (clk),
    .rstn  (rstn),
    .in_i  (opv_q),
    .tag_o (tag_c),
    .any_o (any_c)
  );

  assign accept_c = s_valid & s_ready_q;

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    wei_d     = '0;
    fm_d      = '0;
    opv_d     = 1'b0;
    done_d    = 1'b0;
    clamp_c   = 1'b0;

    if (tag_c) begin
      acc_d = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'($signed(dsp_res)), ACC_W, clamp_c));
      if (clamp_c) begin
        sat_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          remain_d = cfg_len;
          acc_d    = '0;
          sat_d    = 1'b0;
          state_d  = (cfg_len == '0) ? ST_OUT : ST_FEED;
        end
      end
      ST_FEED: begin
        if (accept_c) begin
          wei_d    = s_wei;
          fm_d     = s_fm;
          opv_d    = 1'b1;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!opv_q && !any_c) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d != ST_IDLE);
    s_ready_d = (state_d == ST_FEED);
    m_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      remain_q  <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      wei_q     <= '0;
      fm_q      <= '0;
      opv_q     <= 1'b0;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      wei_q     <= wei_d;
      fm_q      <= fm_d;
      opv_q     <= opv_d;
      busy_q    <= busy_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign s_ready = s_ready_q;
  assign dsp_wei = wei_q;
  assign dsp_fm  = fm_q;
  assign m_data  = acc_q;
  assign m_sat   = sat_q;
  assign m_valid = m_valid_q;

endmodule

// File: doc/dsp_dot_sequencer.md
# dsp_dot_sequencer

Job-level driver and collector for a `dsp_group` instance (N_MUL lanes of 16-bit multiply, 16-bit summed result, fixed pipeline latency).
- Accepts a stream of packed weight/feature-map beats and issues one beat per cycle to the group's `wei`/`fm` inputs.
- Tags issued beats through a latency-matched shift register.
- Accumulates the returned 16-bit `res` values into a signed dot product.
- Emits one accumulated result per job over a valid/ready handshake.
- Sits between the DDR-fed operand FIFOs and the result writeback path.

## Interface
Parameters:
- `N_MUL`, 3: lanes per beat; must match the driven `dsp_group`.
- `DSP_LAT`, 7: cycles from `dsp_wei`/`dsp_fm` changing to the matching `dsp_res` being valid.
- `LEN_W`, 16: width of the job length.
- `ACC_W`, 32: signed accumulator width; ≥ 17.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rstn`  in  1  async active-low reset.
- `start`  in  1  job start pulse; honoured only in IDLE.
- `cfg_len`  in  LEN_W  beats in the job; sampled on accepted `start`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on the result handshake.
- `s_wei`  in  16*N_MUL  packed signed weights.
- `s_fm`  in  16*N_MUL  packed signed features.
- `s_valid`  in  1  operand beat valid.
- `s_ready`  out  1  operand beat ready.
- `dsp_wei`  out  16*N_MUL  to `dsp_group.wei`.
- `dsp_fm`  out  16*N_MUL  to `dsp_group.fm`.
- `dsp_res`  in  16  from `dsp_group.res`, signed.
- `m_data`  out  ACC_W  signed dot product.
- `m_sat`  out  1  accumulator saturated during this job.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result ready.

## Operation
- FSM states: IDLE, FEED, DRAIN, OUT.
- IDLE:
  - On `start`: latch `cfg_len` into `remain`, clear `acc` and `m_sat`.
  - Go to FEED, or straight to OUT with `acc`=0 if `cfg_len`=0.
- FEED:
  - `s_ready`=1 while `remain`≠0.
  - Each accepted beat (`s_valid`&`s_ready`) registers `s_wei`/`s_fm` onto `dsp_wei`/`dsp_fm`, decrements `remain`, and pushes a 1 into the tag shift register.
  - Each non-accepted cycle drives all-zero operands and pushes a 0. Zero operands yield zero products, so bubbles are harmless.
  - When the last beat is accepted, go to DRAIN.
- DRAIN:
  - `s_ready`=0; operands are zero.
  - When the tag register is all zero and no tagged result is pending, go to OUT.
- Tagged results: when a tag emerges aligned with `dsp_res`, `acc` ← sat(`acc` + sign-extended `dsp_res`). This happens in FEED and DRAIN.
- Saturation:
  - Clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Set sticky `m_sat` on a clamp.
  - A saturated `acc` continues accumulating from the clamped value.
- OUT:
  - `m_valid`=1, `m_data`=`acc`.
  - On `m_ready`: pulse `done` and return to IDLE.
  - `m_data` and `m_sat` are held stable while `m_valid`&!`m_ready`.
- `start` while `busy` is ignored; `cfg_len` is not re-sampled.
- Reset at any time:
  - State IDLE; tags, `acc`, `remain` cleared.
  - Results in flight inside `dsp_group` are discarded. Its synchronous reset shares `rstn`.

## Timing
- Reset values: `busy`=0, `done`=0, `s_ready`=0, `dsp_wei`=0, `dsp_fm`=0, `m_data`=0, `m_sat`=0, `m_valid`=0.
- A beat accepted at edge k appears on `dsp_wei`/`dsp_fm` after edge k. Its `dsp_res` is valid in the cycle after edge k+DSP_LAT and is added to `acc` at edge k+DSP_LAT+1.
- `s_ready` is high from the cycle after the `start` edge. For `cfg_len`=L with `s_valid` held high, throughput is 1 beat/cycle.
- `m_valid` rises at edge k_last+DSP_LAT+2. `start`→`m_valid` = L+DSP_LAT+2 cycles with no stalls.
- `cfg_len`=0: `m_valid` rises the cycle after `start`.
- `done` is high for exactly one cycle, coincident with the `m_valid`&`m_ready` edge. `busy` falls at the same edge.
- A new `start` is accepted in the cycle after `done` at the earliest.

## Structure
- Put the FSM state encoding and the `sat_add` function (width-parameterised signed add with clamp) in the shared `dsp_pkg` package.
- One sub-module, `tag_delay`: DSP_LAT-deep 1-bit shift register with async reset, plus an any-bit-set output used by DRAIN.

## Test plan
- Basic job: all `wei` lanes=512, all `fm` lanes=100 (each product 100, `res`=300), L=4, `s_valid` held high, `m_ready` high. Expect `m_data`=1200, `m_sat`=0, and `m_valid` exactly 4+DSP_LAT+2 cycles after `start`.
- Gapped input: same operands with `s_valid` toggling 1,0,0,1,… for L=4. Expect `m_data`=1200 and no extra accumulation from bubbles.
- Zero-length job: L=0. Expect `m_data`=0 and `m_valid` the cycle after `start`. A `start` raised during OUT is ignored.
- Saturation: ACC_W=17, `res`=+30000 per beat, L=4. Expect `m_data`=65535 and `m_sat`=1. Repeat with negative operands; expect -65536.
- Backpressure: hold `m_ready`=0 for 10 cycles in OUT. Expect `m_data` stable, `done` low; `done` is a single pulse on release.
- Reset mid-FEED after 2 of 4 beats. Expect all outputs at reset values. A following L=4 job returns 1200, proving stale results were not accumulated.
